// File: rtl/dcache_pkg.sv
// Shared widths, FSM state encoding and line/tag types for the 2-way L1 data cache.
// Optional statistics counters are enabled by defining DCACHE_STATS_EN.
package dcache_pkg;
    localparam int SETS       = 64;
    localparam int LINE_BYTES = 64;
    localparam int ADDR_W     = 32;
    localparam int WAYS       = 2;
    localparam int IDX_W      = $clog2(SETS);
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;
    localparam int WORDS      = LINE_BYTES / 4;
    localparam int WSEL_W     = $clog2(WORDS);
    localparam int LINE_W     = LINE_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE,
        RESP,
        WB,
        FILL_REQ,
        FILL_WAIT
    } state_t;

    typedef logic [LINE_W-1:0] line_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    // Word k of a line lives in bits [32k+31:32k].
    function automatic logic [31:0] get_word(line_t line, logic [WSEL_W-1:0] sel);
        return line[{sel, 5'b0} +: 32];
    endfunction

    function automatic line_t set_word(line_t line, logic [WSEL_W-1:0] sel, logic [31:0] data);
        line_t merged;
        merged = line;
        merged[{sel, 5'b0} +: 32] = data;
        return merged;
    endfunction
endpackage

// File: rtl/dcache_way.sv
// One cache way: valid/dirty bits (reset), tag and data arrays (not reset),
// combinational tag compare and a registered line read for response/writeback data.
module dcache_way
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  tag,
    output logic              hit,
    output tag_entry_t        entry,
    output line_t             line,
    input  logic              word_we,
    input  logic [WSEL_W-1:0] word_sel,
    input  logic [31:0]       word_data,
    input  logic              fill_we,
    input  line_t             fill_line,
    input  logic              fill_dirty,
    input  logic              clr_dirty
);
    logic [SETS-1:0]  valid_reg;
    logic [SETS-1:0]  dirty_reg;
    logic [TAG_W-1:0] tag_mem [SETS];
    line_t            data_mem [SETS];
    line_t            line_reg;

    assign entry = '{valid: valid_reg[idx], dirty: dirty_reg[idx], tag: tag_mem[idx]};
    assign hit   = valid_reg[idx] && (tag_mem[idx] == tag);
    assign line  = line_reg;

    // Valid/dirty state: fills install a line, store hits dirty it, writebacks clean it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (fill_we) begin
            valid_reg[idx] <= 1'b1;
            dirty_reg[idx] <= fill_dirty;
        end else if (word_we) begin
            dirty_reg[idx] <= 1'b1;
        end else if (clr_dirty) begin
            dirty_reg[idx] <= 1'b0;
        end
    end

    // Tag/data storage with read-before-write registered line read.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= fill_line;
        end else if (word_we) begin
            data_mem[idx][{word_sel, 5'b0} +: 32] <= word_data;
        end
        line_reg <= data_mem[idx];
    end
endmodule

// File: rtl/data_cache.sv
// 2-way set-associative write-back/write-allocate L1 data cache top: two ways,
// per-set LRU bits and the miss FSM. Define DCACHE_STATS_EN for hit/miss counters.
module data_cache
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output line_t             mem_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  line_t             mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    state_t            state_reg, state_next;
    logic              wr_reg, victim_reg, hit_way_reg, from_fill_reg;
    logic [31:0]       wdata_reg, fill_word_reg;
    logic [TAG_W-1:0]  tag_reg, victim_tag_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [WSEL_W-1:0] word_reg;
    logic [SETS-1:0]   lru_reg;   // 1 = way1 is least recently used

    logic [TAG_W-1:0]  req_tag, lookup_tag;
    logic [IDX_W-1:0]  req_idx, lookup_idx;
    logic [WSEL_W-1:0] req_word;
    logic              accept, hit_any, victim_sel, victim_dirty, fill_done;
    logic              unused_addr_bits;
    logic [WAYS-1:0]   way_hit, way_word_we, way_fill_we, way_clr_dirty;
    tag_entry_t        way_entry [WAYS];
    line_t             way_line [WAYS];
    line_t             fill_line;

    assign req_tag          = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx          = req_addr[OFF_W +: IDX_W];
    assign req_word         = req_addr[2 +: WSEL_W];
    assign unused_addr_bits = &{1'b1, req_addr[1:0]};

    // Lookups use the live request while idle, the latched request during a miss.
    assign lookup_idx = (state_reg == IDLE) ? req_idx : idx_reg;
    assign lookup_tag = (state_reg == IDLE) ? req_tag : tag_reg;
    assign accept     = (state_reg == IDLE) && req_valid;
    assign hit_any    = |way_hit;
    assign fill_done  = (state_reg == FILL_WAIT) && mem_resp_valid;
    assign fill_line  = wr_reg ? set_word(mem_rdata, word_reg, wdata_reg) : mem_rdata;

    // Victim choice: an invalid way (way0 first), otherwise the LRU way.
    always_comb begin
        if (!way_entry[0].valid)      victim_sel = 1'b0;
        else if (!way_entry[1].valid) victim_sel = 1'b1;
        else                          victim_sel = lru_reg[req_idx];
    end

    assign victim_dirty = way_entry[victim_sel].valid && way_entry[victim_sel].dirty;

    genvar gi;
    for (gi = 0; gi < WAYS; gi++) begin : g_way
        assign way_word_we[gi]   = accept && way_hit[gi] && req_write;
        assign way_fill_we[gi]   = fill_done && (victim_reg == 1'(gi));
        assign way_clr_dirty[gi] = (state_reg == WB) && mem_req_ready && (victim_reg == 1'(gi));

        dcache_way u_way (
            .clk        (clk),
            .rst        (rst),
            .idx        (lookup_idx),
            .tag        (lookup_tag),
            .hit        (way_hit[gi]),
            .entry      (way_entry[gi]),
            .line       (way_line[gi]),
            .word_we    (way_word_we[gi]),
            .word_sel   (req_word),
            .word_data  (req_wdata),
            .fill_we    (way_fill_we[gi]),
            .fill_line  (fill_line),
            .fill_dirty (wr_reg),
            .clr_dirty  (way_clr_dirty[gi])
        );
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Request latch plus the response word captured when a fill completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_reg         <= 1'b0;
            wdata_reg      <= '0;
            tag_reg        <= '0;
            idx_reg        <= '0;
            word_reg       <= '0;
            victim_reg     <= 1'b0;
            victim_tag_reg <= '0;
            hit_way_reg    <= 1'b0;
            from_fill_reg  <= 1'b0;
            fill_word_reg  <= '0;
        end else begin
            if (accept) begin
                wr_reg         <= req_write;
                wdata_reg      <= req_wdata;
                tag_reg        <= req_tag;
                idx_reg        <= req_idx;
                word_reg       <= req_word;
                victim_reg     <= victim_sel;
                victim_tag_reg <= way_entry[victim_sel].tag;
                hit_way_reg    <= way_hit[1];
                from_fill_reg  <= 1'b0;
            end
            if (fill_done) begin
                from_fill_reg <= 1'b1;
                fill_word_reg <= get_word(fill_line, word_reg);
            end
        end
    end

    // LRU update: the way just hit or just filled becomes MRU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   lru_reg <= '0;
        else if (accept && hit_any) lru_reg[req_idx] <= !way_hit[1];
        else if (fill_done)         lru_reg[idx_reg] <= !victim_reg;
    end

`ifdef DCACHE_STATS_EN
    // Hit/miss statistics, one count per accepted request, wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit_any) hit_count  <= hit_count + 32'd1;
            else         miss_count <= miss_count + 32'd1;
        end
    end
`endif

    // Next-state and output decode.
    always_comb begin
        state_next    = state_reg;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_wdata     = '0;
        unique case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (hit_any)           state_next = RESP;
                    else if (victim_dirty) state_next = WB;
                    else                   state_next = FILL_REQ;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (!wr_reg)
                    resp_rdata = from_fill_reg ? fill_word_reg
                                               : get_word(way_line[hit_way_reg], word_reg);
                state_next = IDLE;
            end
            WB: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {victim_tag_reg, idx_reg, {OFF_W{1'b0}}};
                mem_wdata     = way_line[victim_reg];
                if (mem_req_ready) state_next = FILL_REQ;
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag_reg, idx_reg, {OFF_W{1'b0}}};
                if (mem_req_ready) state_next = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_resp_valid) state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache; the bench plays the memory controller.
module tb_data_cache;
    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_write;
    logic [31:0]  req_addr, req_wdata;
    logic         req_ready, resp_valid;
    logic [31:0]  resp_rdata;
    logic         mem_req_valid, mem_req_write;
    logic [31:0]  mem_req_addr;
    logic [511:0] mem_wdata;
    logic         mem_req_ready, mem_resp_valid;
    logic [511:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [511:0] line1, line2, line3, wb_exp;

    always #5 clk = ~clk;

    data_cache dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_wdata      (mem_wdata),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; afterwards the DUT has moved past IDLE.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        $display("request %s addr=%08h wdata=%08h", wr ? "store" : "load ", addr, data);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    // Accept a fill request and return the line; afterwards the DUT is in RESP.
    task automatic fill(input logic [511:0] line);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("fill_wait_quiet", mem_req_valid, 1'b0);
        mem_resp_valid = 1'b1;
        mem_rdata      = line;
        tick();
        mem_resp_valid = 1'b0;
        $display("fill returned line word0=%08h", line[31:0]);
    endtask

    function automatic logic [511:0] base_line(input logic [31:0] base);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    function automatic logic [511:0] put_word(input logic [511:0] l, input int k, input logic [31:0] v);
        logic [511:0] r;
        r = l;
        r[32*k +: 32] = v;
        return r;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        chk({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        chk({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
        chk({tag, "_mem_req_write"}, mem_req_write, 1'b0);
        chk({tag, "_mem_req_addr"}, mem_req_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 512'h0);
    endtask

    initial begin
        line1  = put_word(base_line(32'h1111_0000), 1, 32'hDEAD_BEEF);
        line2  = base_line(32'hAAAA_0000);
        line3  = base_line(32'h3333_0000);
        wb_exp = put_word(line1, 2, 32'h1234_5678);

        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Cold load misses into an empty set: fill only, no writeback.
        issue(1'b0, 32'h0000_1004, 32'h0);
        chk("cold_req_valid", mem_req_valid, 1'b1);
        chk("cold_req_write", mem_req_write, 1'b0);
        chk("cold_req_addr", mem_req_addr, 32'h0000_1000);
        chk("cold_not_ready", req_ready, 1'b0);
        fill(line1);
        chk("cold_resp_valid", resp_valid, 1'b1);
        chk("cold_rdata", resp_rdata, 32'hDEAD_BEEF);
        tick();
        chk("cold_resp_pulse", resp_valid, 1'b0);
        chk("cold_back_idle", req_ready, 1'b1);

        // Repeat load hits with one-cycle latency.
        issue(1'b0, 32'h0000_1004, 32'h0);
        chk("hit_resp_valid", resp_valid, 1'b1);
        chk("hit_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("hit_no_mem", mem_req_valid, 1'b0);
        tick();

        // Store hit, then read it back.
        issue(1'b1, 32'h0000_1008, 32'h1234_5678);
        chk("store_resp_valid", resp_valid, 1'b1);
        chk("store_rdata_zero", resp_rdata, 32'h0);
        chk("store_no_mem", mem_req_valid, 1'b0);
        tick();
        issue(1'b0, 32'h0000_1008, 32'h0);
        chk("store_readback", resp_rdata, 32'h1234_5678);
        chk("readback_no_mem", mem_req_valid, 1'b0);
        tick();

        // Second line in set 0 goes to the empty way.
        issue(1'b0, 32'h0000_2000, 32'h0);
        chk("way1_fill_write", mem_req_write, 1'b0);
        chk("way1_fill_addr", mem_req_addr, 32'h0000_2000);
        fill(line2);
        chk("way1_rdata", resp_rdata, 32'hAAAA_0000);
        tick();

        // Third line evicts the dirty LRU line 0x1000; memory stalls in WB.
        issue(1'b0, 32'h0000_3000, 32'h0);
        for (int i = 0; i < 10; i++) begin
            chk("wb_valid", mem_req_valid, 1'b1);
            chk("wb_write", mem_req_write, 1'b1);
            chk("wb_addr", mem_req_addr, 32'h0000_1000);
            chk("wb_wdata", mem_wdata, wb_exp);
            chk("wb_not_ready", req_ready, 1'b0);
            mem_resp_valid = (i == 3);
            req_valid      = (i == 5);
            req_addr       = 32'h0000_1004;
            tick();
        end
        mem_resp_valid = 1'b0;
        req_valid      = 1'b0;
        chk("wb_still_held", mem_wdata, wb_exp);
        mem_req_ready = 1'b1;
        tick();
        chk("evict_fill_valid", mem_req_valid, 1'b1);
        chk("evict_fill_write", mem_req_write, 1'b0);
        chk("evict_fill_addr", mem_req_addr, 32'h0000_3000);
        fill(line3);
        chk("evict_rdata", resp_rdata, 32'h3333_0000);
        tick();

        // The surviving line still hits.
        issue(1'b0, 32'h0000_2000, 32'h0);
        chk("survivor_resp_valid", resp_valid, 1'b1);
        chk("survivor_rdata", resp_rdata, 32'hAAAA_0000);
        chk("survivor_no_mem", mem_req_valid, 1'b0);
        tick();

        // Reset while waiting for fill data.
        issue(1'b0, 32'h0000_5000, 32'h0);
        chk("abort_fill_addr", mem_req_addr, 32'h0000_5000);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("abort_in_wait", req_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        tick();
        rst = 1'b1;
        tick();
        issue(1'b0, 32'h0000_1004, 32'h0);
        chk("post_reset_miss", mem_req_valid, 1'b1);
        chk("post_reset_addr", mem_req_addr, 32'h0000_1000);
        fill(line1);
        chk("post_reset_rdata", resp_rdata, 32'hDEAD_BEEF);
        tick();

        // Store miss into the last word of a line merges into the fill.
        issue(1'b1, 32'h0000_203C, 32'hCAFE_F00D);
        chk("store_miss_addr", mem_req_addr, 32'h0000_2000);
        chk("store_miss_write", mem_req_write, 1'b0);
        fill(line2);
        chk("store_miss_resp", resp_valid, 1'b1);
        chk("store_miss_rdata", resp_rdata, 32'h0);
        tick();
        issue(1'b0, 32'h0000_203C, 32'h0);
        chk("merged_word15", resp_rdata, 32'hCAFE_F00D);
        tick();
        issue(1'b0, 32'h0000_2038, 32'h0);
        chk("unmerged_word14", resp_rdata, 32'hAAAA_000E);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
